ring_rx_sync: RTL and testbench
===============================

Name: ring_rx_sync

Overview:
- Downstream consumer of the asynchronous ring's output channel.
- Receives the ring's 4-phase bundled-data handshake (rr/ra, 32-bit dout) and synchronizes it into the clk domain.
- Buffers received words in a small FIFO and presents them as a clocked valid/ready stream.
- Measures the ring's inter-token period in clk cycles, for on-chip cycle-time characterization.

Parameters:
- DW, 32: data width; matches ring dout.
- DEPTH, 4: FIFO depth; power of 2, minimum 2.
- SYNC_STAGES, 2: flops in the req synchronizer; minimum 2.
- CNT_W, 16: period counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- req_i  in  1  4-phase request from the ring (rr); asynchronous.
- ack_o  out  1  4-phase acknowledge to the ring (ra); registered.
- data_i  in  DW  bundled data (dout); stable while req_i=1 until ack_o=1.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  downstream accept.
- m_data  out  DW  FIFO head word.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- period_o  out  CNT_W  clk cycles between the last two captures; saturating.
- period_valid  out  1  one-cycle pulse when period_o updates.

Behaviour:
- Reset (clk edge with rst=0):
  - Synchronizer flops, ack_o, m_valid, level, period_o, period_valid and counter are all 0.
  - FIFO pointers are cleared.
  - FSM goes to ARM.
- req_s is the output of a SYNC_STAGES flop chain on req_i. FSM logic uses only req_s and never req_i directly.
- FSM:
  - ARM: wait for req_s=0, then go to IDLE. This prevents capturing a stale token when reset is released while req_i is held high.
  - IDLE: if req_s=1 and not full, capture data_i into the FIFO (push), set ack_o=1, go to HOLD. If full, stay in IDLE with ack_o=0; this is backpressure to the ring.
  - HOLD: when req_s=0, set ack_o=0 and go to IDLE.
- Timing:
  - Latency req_i rise to ack_o rise is SYNC_STAGES+1 cycles when not full.
  - Latency req_i fall to ack_o fall is SYNC_STAGES+1 cycles.
- Capture correctness: data is sampled only after req_s=1, and the bundled-data constraint guarantees data_i is settled by then. data_i is never sampled in any other state.
- FIFO:
  - Registered head; m_data is valid when m_valid=1.
  - A push becomes visible on m_valid the cycle after capture.
  - Pop occurs when m_valid & m_ready.
  - Full is evaluated before that cycle's pop: full with a simultaneous pop does not capture that cycle; capture happens the next cycle.
  - Push and pop in the same cycle when not full leaves level unchanged.
  - Pointers wrap modulo DEPTH.
  - m_data is unchanged while m_valid=1 and m_ready=0.
- Period counter:
  - Free-running from the first capture after reset; saturates at 2^CNT_W-1.
  - On each capture after the first: period_o takes the counter value, period_valid pulses for one cycle, and the counter restarts at 1.
  - The first capture only starts the counter; there is no pulse.
- Reset mid-operation (for example in HOLD with ack_o=1): ack_o drops on the reset edge, FIFO contents are discarded, and the block passes through ARM. The ring's outstanding token is not captured twice.
- level equals the push count minus the pop count; it never exceeds DEPTH.

Decomposition:
- Shared package ring_rx_pkg:
  - FSM state enum {ARM, IDLE, HOLD}.
  - Localparam for the pointer width, $clog2(DEPTH).
- One sub-module, ring_rx_fifo: DW/DEPTH parameterized, synchronous active-low reset, push/pop/full/empty/level.
- The synchronizer and FSM stay in the top module.

Test Plan:
- Basic transfer: reset 3 cycles; req_i=1 with data_i=32'hDEADBEEF, held until ack_o=1, then dropped. Required:
  - ack_o rises SYNC_STAGES+1 cycles after req_i rises.
  - m_valid=1 with m_data=DEADBEEF the following cycle.
  - ack_o falls SYNC_STAGES+1 cycles after req_i falls.
- Backpressure: m_ready=0; send 5 tokens 0x1..0x5 with DEPTH=4. Required:
  - Tokens 1-4 are acked and level reaches 4.
  - Token 5 is not acked while full.
  - Pulse m_ready for 1 cycle: pop 0x1, then capture 0x5 the next cycle.
  - Drain order is 1,2,3,4,5.
- Period measurement: send tokens every 20 clk cycles (full 4-phase each). Required:
  - No period_valid on the first capture.
  - Thereafter period_valid pulses with period_o=20 on each capture.
  - With CNT_W=4 and 40-cycle spacing, period_o=15 (saturated).
- Reset in HOLD: drive req_i=1, reach ack_o=1, assert rst=0 for 1 cycle with req_i still high. Required:
  - ack_o=0 and level=0.
  - No new capture until req_i falls and rises again with data_i=0xCAFE0001.
  - Exactly one word, 0xCAFE0001, is output.
- Simultaneous push/pop: level=2, m_ready=1, token arrives. Required:
  - level stays 2 in the capture cycle.
  - Output order is preserved across pointer wrap after 10 tokens (values 0..9).

Source files
------------

// File: rtl/ring_rx_pkg.sv
// Shared types and constants for the ring receive-side synchronizer and its FIFO.
package ring_rx_pkg;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    HOLD = 2'd2
  } rx_state_e;

  localparam int unsigned RX_DEPTH = 4;
  localparam int unsigned RX_PTR_W = $clog2(RX_DEPTH);

endpackage

// File: rtl/ring_rx_fifo.sv
// Small FIFO with a registered head word; DEPTH must be a power of two.
module ring_rx_fifo
  import ring_rx_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = RX_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DW-1:0]            rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] rd_nxt_s;
  logic [AW:0]   count_r;
  logic [AW:0]   count_nxt_s;
  logic [DW-1:0] head_r;
  logic          valid_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = ~valid_r;
  assign level     = count_r;
  assign rdata     = head_r;
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & valid_r;

  always_comb begin
    rd_nxt_s    = rd_ptr_r;
    count_nxt_s = count_r;
    if (pop_ok_s) begin
      rd_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_nxt_s = rd_ptr_r;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // The head register tracks the entry at the next read pointer, bypassing a
  // push that lands there (only possible when the FIFO drains to empty).
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      head_r   <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_nxt_s;
      count_r  <= count_nxt_s;
      valid_r  <= (count_nxt_s != '0);
      if (push_ok_s && (wr_ptr_r == rd_nxt_s)) begin
        head_r <= wdata;
      end else begin
        head_r <= mem_r[rd_nxt_s];
      end
    end
  end

endmodule

// File: rtl/ring_rx_sync.sv
// Receives the async ring's 4-phase bundled-data channel into the clk domain,
// buffers words in a FIFO and measures the inter-token period.
module ring_rx_sync
  import ring_rx_pkg::*;
#(
  parameter int DW          = 32,
  parameter int DEPTH       = RX_DEPTH,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  output logic                   ack_o,
  input  logic [DW-1:0]          data_i,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DW-1:0]          m_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       period_o,
  output logic                   period_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_r;
  logic [SYNC_STAGES-1:0] fill_r;
  logic                   req_s;
  logic                   sync_ok_s;
  rx_state_e              state_r;
  rx_state_e              state_nxt_s;
  logic                   ack_r;
  logic                   ack_nxt_s;
  logic                   push_s;
  logic                   full_s;
  logic                   empty_s;
  logic [CNT_W-1:0]       cnt_r;
  logic                   started_r;
  logic [CNT_W-1:0]       period_r;
  logic                   period_valid_r;

  // fill_r marks when the chain holds real samples again after reset, so ARM
  // never mistakes the cleared chain for a low request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_r <= '0;
      fill_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], req_i};
      fill_r <= {fill_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign req_s     = sync_r[SYNC_STAGES-1];
  assign sync_ok_s = fill_r[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ARM;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= ack_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    ack_nxt_s   = ack_r;
    push_s      = 1'b0;
    case (state_r)
      ARM: begin
        ack_nxt_s = 1'b0;
        if (sync_ok_s && !req_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ARM;
        end
      end
      IDLE: begin
        if (req_s && !full_s) begin
          push_s      = 1'b1;
          ack_nxt_s   = 1'b1;
          state_nxt_s = HOLD;
        end else begin
          ack_nxt_s   = 1'b0;
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (!req_s) begin
          ack_nxt_s   = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          ack_nxt_s   = 1'b1;
          state_nxt_s = HOLD;
        end
      end
      default: begin
        ack_nxt_s   = 1'b0;
        state_nxt_s = ARM;
      end
    endcase
  end

  // Counter restarts at 1 on the capture edge so it reads N at a capture N cycles later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r          <= '0;
      started_r      <= 1'b0;
      period_r       <= '0;
      period_valid_r <= 1'b0;
    end else begin
      period_valid_r <= 1'b0;
      if (push_s) begin
        cnt_r     <= CNT_W'(1);
        started_r <= 1'b1;
        if (started_r) begin
          period_r       <= cnt_r;
          period_valid_r <= 1'b1;
        end
      end else if (started_r && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  ring_rx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (data_i),
    .pop   (m_ready),
    .full  (full_s),
    .empty (empty_s),
    .level (level),
    .rdata (m_data)
  );

  assign ack_o        = ack_r;
  assign m_valid      = ~empty_s;
  assign period_o     = period_r;
  assign period_valid = period_valid_r;

endmodule

// File: tb/tb_ring_rx_sync.sv
// Self-checking bench for ring_rx_sync: scoreboarded FIFO output plus tables
// for period measurement and simultaneous push/pop across pointer wrap.
module tb_ring_rx_sync;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] data_i = 32'h0;

  logic        ack_a, m_valid_a, pv_a;
  logic [31:0] m_data_a;
  logic [2:0]  level_a;
  logic [15:0] period_a;
  logic        ack_b, m_valid_b, pv_b;
  logic [31:0] m_data_b;
  logic [2:0]  level_b;
  logic [3:0]  period_b;

  ring_rx_sync #(.DW(32), .DEPTH(4), .SYNC_STAGES(SS), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .ack_o(ack_a), .data_i(data_i),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .level(level_a),
    .period_o(period_a), .period_valid(pv_a)
  );

  ring_rx_sync #(.DW(32), .DEPTH(4), .SYNC_STAGES(SS), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .req_i(req_i), .ack_o(ack_b), .data_i(data_i),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .level(level_b),
    .period_o(period_b), .period_valid(pv_b)
  );

  always #5 clk = ~clk;

  logic [31:0] sb_q [$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int pop_cnt = 0;

  typedef struct {
    logic [31:0] data;
    int          gap;
    logic        exp_pv;
    logic [15:0] exp_pa;
    logic [3:0]  exp_pb;
  } per_t;

  typedef struct {
    logic [31:0] data;
    logic        ready;
    logic [2:0]  exp_level;
  } pp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every word leaving the FIFO must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && m_valid_a && m_ready) begin
      pop_cnt++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_word", m_data_a, 32'hFFFF_FFFF);
      end else begin
        check("sb_data", m_data_a, sb_q.pop_front());
      end
    end
  end

  task automatic raise(input logic [31:0] d);
    @(posedge clk);
    #1 req_i = 1'b1;
    data_i = d;
  endtask

  task automatic drop();
    @(posedge clk);
    #1 req_i = 1'b0;
  endtask

  task automatic wait_ack(input logic val, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ack_a !== val) && (n < budget));
    if (ack_a !== val) check("ack_timeout", {31'd0, ack_a}, {31'd0, val});
  endtask

  task automatic drain();
    int n;
    @(posedge clk);
    #1 m_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_valid_a && (n < 40));
    @(posedge clk);
    #1 m_ready = 1'b0;
    check("drain_level", {29'd0, level_a}, 32'd0);
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    raise(d);
    sb_q.push_back(d);
    wait_ack(1'b1, 20, n);
    drop();
    wait_ack(1'b0, 20, n);
  endtask

  initial begin
    per_t   per_tab [5];
    pp_t    pp_tab [10];
    int     n;
    logic   saw;
    int     pop_before;
    longint t_prev;
    longint t_next;
    logic [0:9] rdy;
    logic [2:0] lvl [10];

    per_tab[0] = '{32'hA000_0000, 0,  1'b0, 16'd0,  4'd0};
    per_tab[1] = '{32'hA000_0001, 20, 1'b1, 16'd20, 4'd15};
    per_tab[2] = '{32'hA000_0002, 20, 1'b1, 16'd20, 4'd15};
    per_tab[3] = '{32'hA000_0003, 40, 1'b1, 16'd40, 4'd15};
    per_tab[4] = '{32'hA000_0004, 40, 1'b1, 16'd40, 4'd15};
    rdy = 10'b0011011110;
    lvl = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    for (int i = 0; i < 10; i++) pp_tab[i] = '{i, rdy[i], lvl[i]};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'd0, ack_a}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid_a}, 32'd0);
    check("rst_level", {29'd0, level_a}, 32'd0);
    check("rst_pv", {31'd0, pv_a}, 32'd0);
    check("rst_period", {16'd0, period_a}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);

    // Basic transfer
    raise(32'hDEAD_BEEF);
    sb_q.push_back(32'hDEAD_BEEF);
    wait_ack(1'b1, 20, n);
    check("basic_rise_latency", n - 1, SS + 1);
    @(negedge clk);
    check("basic_m_valid", {31'd0, m_valid_a}, 32'd1);
    check("basic_m_data", m_data_a, 32'hDEAD_BEEF);
    drop();
    wait_ack(1'b0, 20, n);
    check("basic_fall_latency", n - 1, SS + 1);
    drain();

    // Backpressure with a full FIFO
    for (int i = 1; i <= 4; i++) send(i);
    check("bp_level_full", {29'd0, level_a}, 32'd4);
    raise(32'd5);
    sb_q.push_back(32'd5);
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw = saw | ack_a;
    end
    check("bp_no_ack_when_full", {31'd0, saw}, 32'd0);
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    check("bp_pop_cycle_ack", {31'd0, ack_a}, 32'd0);
    check("bp_pop_cycle_level", {29'd0, level_a}, 32'd3);
    @(negedge clk);
    check("bp_capture_ack", {31'd0, ack_a}, 32'd1);
    check("bp_capture_level", {29'd0, level_a}, 32'd4);
    drop();
    wait_ack(1'b0, 20, n);
    drain();

    // Period measurement, both counter widths
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 m_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      t_next = t_prev + per_tab[i].gap * 10;
      do @(posedge clk); while ($time + 1 < t_next);
      #1 req_i = 1'b1;
      data_i = per_tab[i].data;
      t_prev = $time;
      sb_q.push_back(per_tab[i].data);
      wait_ack(1'b1, 20, n);
      check("per_pv", {31'd0, pv_a}, {31'd0, per_tab[i].exp_pv});
      check("per_pv_sat", {31'd0, pv_b}, {31'd0, per_tab[i].exp_pv});
      if (per_tab[i].exp_pv) begin
        check("per_period", {16'd0, period_a}, {16'd0, per_tab[i].exp_pa});
        check("per_period_sat", {28'd0, period_b}, {28'd0, per_tab[i].exp_pb});
      end
      @(negedge clk);
      check("per_pv_one_cycle", {31'd0, pv_a}, 32'd0);
      drop();
      wait_ack(1'b0, 20, n);
    end
    @(posedge clk);
    #1 m_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while holding ack high
    raise(32'hBAD0_0BAD);
    wait_ack(1'b1, 20, n);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("hold_rst_ack", {31'd0, ack_a}, 32'd0);
    check("hold_rst_level", {29'd0, level_a}, 32'd0);
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw = saw | ack_a | (level_a != 3'd0);
    end
    check("hold_rst_no_recapture", {31'd0, saw}, 32'd0);
    drop();
    repeat (6) begin
      @(negedge clk);
      saw = saw | ack_a | (level_a != 3'd0);
    end
    check("hold_rst_quiet_after_drop", {31'd0, saw}, 32'd0);
    pop_before = pop_cnt;
    send(32'hCAFE_0001);
    drain();
    check("hold_rst_one_word", pop_cnt - pop_before, 32'd1);

    // Simultaneous push/pop and pointer wrap
    for (int i = 0; i < 10; i++) begin
      raise(pp_tab[i].data);
      sb_q.push_back(pp_tab[i].data);
      @(posedge clk);
      @(posedge clk);
      #1 m_ready = pp_tab[i].ready;
      @(posedge clk);
      #1 m_ready = 1'b0;
      @(negedge clk);
      check("pp_ack", {31'd0, ack_a}, 32'd1);
      check("pp_level", {29'd0, level_a}, {29'd0, pp_tab[i].exp_level});
      drop();
      wait_ack(1'b0, 20, n);
    end
    drain();

    check("sb_all_consumed", sb_q.size(), 32'd0);
    check("sat_dut_empty", {29'd0, level_b}, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
